// File: rtl/mac_ram_output.sv
// Signed int8 multiply-accumulate lane plus a 64-entry append-only result store
// with a combinational read port.
module mac_ram_output #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 19,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  inA,
  input  logic signed [IN_W-1:0]  inB,
  input  logic                    clr,
  output logic signed [ACC_W-1:0] out,
  input  logic signed [ACC_W-1:0] wr_data,
  input  logic                    write_enable,
  input  logic [AW-1:0]           rd_addr,
  output logic signed [ACC_W-1:0] rd_data,
  output logic [AW:0]             wr_count,
  output logic                    full
);

  localparam int unsigned PW = 2 * IN_W;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic signed [PW-1:0]    w_product;
  logic signed [ACC_W-1:0] w_product_ext;
  logic signed [ACC_W-1:0] w_acc_d;
  logic                    w_wr_accept;

  logic signed [ACC_W-1:0] r_acc;
  logic [AW:0]             r_count;
  logic signed [ACC_W-1:0] r_mem [DEPTH];

  always_comb begin
    w_product     = inA * inB;
    w_product_ext = {{(ACC_W - PW){w_product[PW-1]}}, w_product};
    // clr restarts the sum with this cycle's product, so dot products run back to back
    w_acc_d       = clr ? w_product_ext : r_acc + w_product_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_d;
    end
  end

  assign w_wr_accept = write_enable && !full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wr_accept) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_accept) begin
      r_mem[r_count[AW-1:0]] <= wr_data;
    end
  end

  assign out      = r_acc;
  assign wr_count = r_count;
  assign full     = (r_count == FULL_COUNT);
  assign rd_data  = r_mem[rd_addr];

endmodule

// File: tb/tb_mac_ram_output.sv
// Scoreboard bench for mac_ram_output: MAC results and accepted store writes are
// queued as they are driven and compared when the DUT produces them.
module tb_mac_ram_output;

  localparam int IN_W  = 8;
  localparam int ACC_W = 19;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic                    clk;
  logic                    reset;
  logic signed [IN_W-1:0]  inA;
  logic signed [IN_W-1:0]  inB;
  logic                    clr;
  logic signed [ACC_W-1:0] out;
  logic signed [ACC_W-1:0] wr_data;
  logic                    write_enable;
  logic [AW-1:0]           rd_addr;
  logic signed [ACC_W-1:0] rd_data;
  logic [AW:0]             wr_count;
  logic                    full;

  int n_tests;
  int n_fail;

  logic signed [ACC_W-1:0] m_acc;
  int                      m_count;
  logic signed [ACC_W-1:0] mac_q[$];
  logic signed [ACC_W-1:0] store_q[$];

  mac_ram_output #(
    .IN_W (IN_W),
    .ACC_W(ACC_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inA         (inA),
    .inB         (inB),
    .clr         (clr),
    .out         (out),
    .wr_data     (wr_data),
    .write_enable(write_enable),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_count    (wr_count),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mac_step(input int a, input int b, input bit c);
    int p;
    logic signed [ACC_W-1:0] exp_v;
    @(negedge clk);
    inA = IN_W'(a);
    inB = IN_W'(b);
    clr = c;
    p = a * b;
    if (c) m_acc = ACC_W'(p);
    else   m_acc = m_acc + ACC_W'(p);
    mac_q.push_back(m_acc);
    @(posedge clk);
    #1;
    exp_v = mac_q.pop_front();
    n_tests++;
    if (out !== exp_v) begin
      n_fail++;
      $display("FAIL mac_step a=%0d b=%0d clr=%0b: out=%0d expected=%0d", a, b, c, out, exp_v);
    end
  endtask

  task automatic check_out_const(input string name, input int exp_v);
    n_tests++;
    if (out !== ACC_W'(exp_v)) begin
      n_fail++;
      $display("FAIL %s: out=%0d expected=%0d", name, out, exp_v);
    end
  endtask

  task automatic store_write(input int v, input bit we);
    @(negedge clk);
    wr_data      = ACC_W'(v);
    write_enable = we;
    if (we && m_count < DEPTH) begin
      store_q.push_back(ACC_W'(v));
      m_count++;
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (wr_count !== (AW + 1)'(m_count)) begin
      n_fail++;
      $display("FAIL store_count v=%0d we=%0b: wr_count=%0d expected=%0d", v, we, wr_count,
               m_count);
    end
  endtask

  task automatic async_reset_check(input string name);
    bit bad;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (out !== '0 || wr_count !== '0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_immediate: out=%0d wr_count=%0d full=%0b expected 0 0 0", name, out,
               wr_count, full);
    end
    bad = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr = AW'(k);
      #0.1;
      if (rd_data !== '0) begin
        bad = 1'b1;
        $display("FAIL %s_mem addr=%0d: rd_data=%0d expected=0", name, k, rd_data);
      end
    end
    n_tests++;
    if (bad) n_fail++;
    @(negedge clk);
    reset = 1'b0;
    m_acc   = '0;
    m_count = 0;
    mac_q.delete();
    store_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    mac_step(5, 5, 1'b1);
    store_write(7, 1'b1);
    write_enable = 1'b0;
    async_reset_check("reset");
  endtask

  task automatic test_dot_product();
    int exp_seq [8] = '{1, 3, 6, 10, 15, 21, 28, 36};
    for (int i = 0; i < 8; i++) begin
      mac_step(i + 1, 1, i == 0);
      check_out_const($sformatf("dot_seq_%0d", i), exp_seq[i]);
    end
    mac_step(2, 3, 1'b1);
    check_out_const("back_to_back", 6);
  endtask

  task automatic test_signed_extremes();
    for (int i = 0; i < 8; i++) mac_step(-128, -128, i == 0);
    check_out_const("neg_neg_sum", 131072);
    for (int i = 0; i < 8; i++) mac_step(-128, 127, i == 0);
    check_out_const("neg_pos_sum", -130048);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) mac_step(-128, -128, i == 0);
    check_out_const("wrap_sum", -262144);
    n_tests++;
    if (out !== 19'h40000) begin
      n_fail++;
      $display("FAIL wrap_bits: out=%h expected=40000", out);
    end
  endtask

  task automatic test_store_fill();
    logic signed [ACC_W-1:0] exp_v;
    for (int i = 0; i < DEPTH; i++) store_write(i, 1'b1);
    n_tests++;
    if (full !== 1'b1 || wr_count !== 7'd64) begin
      n_fail++;
      $display("FAIL fill_full: full=%0b wr_count=%0d expected 1 64", full, wr_count);
    end
    store_write(999, 1'b1);
    for (int i = 0; i < 3; i++) store_write(12345, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr = AW'(k);
      #1;
      exp_v = store_q.pop_front();
      n_tests++;
      if (rd_data !== exp_v) begin
        n_fail++;
        $display("FAIL readback addr=%0d: rd_data=%0d expected=%0d", k, rd_data, exp_v);
      end
    end
    rd_addr = '0;
    #1;
    n_tests++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL overflow_mem0: rd_data=%0d expected=0", rd_data);
    end
  endtask

  task automatic test_reset_mid_run();
    mac_step(3, 4, 1'b1);
    mac_step(5, 6, 1'b0);
    mac_step(7, 8, 1'b0);
    store_write(m_count, 1'b0);
    async_reset_check("prefill_reset");
    for (int i = 0; i < 5; i++) store_write(100 + i, 1'b1);
    mac_step(3, 4, 1'b1);
    mac_step(5, 6, 1'b0);
    mac_step(7, 8, 1'b0);
    write_enable = 1'b0;
    async_reset_check("mid_run_reset");
    rd_addr = '0;
    @(negedge clk);
    wr_data      = 19'sd55;
    write_enable = 1'b1;
    #1;
    n_tests++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL pre_write_read: rd_data=%0d expected=0", rd_data);
    end
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    n_tests++;
    if (rd_data !== 19'sd55 || wr_count !== 7'd1) begin
      n_fail++;
      $display("FAIL post_reset_write: rd_data=%0d wr_count=%0d expected 55 1", rd_data,
               wr_count);
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    m_acc        = '0;
    m_count      = 0;
    reset        = 1'b0;
    inA          = '0;
    inB          = '0;
    clr          = 1'b0;
    wr_data      = '0;
    write_enable = 1'b0;
    rd_addr      = '0;
    test_reset();
    test_dot_product();
    test_signed_extremes();
    test_wrap();
    test_store_fill();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_ram_output.md
Name: mac_ram_output

Overview:
- Datapath leaf for the 8x8 int8 matrix-multiply engine: one signed multiply-accumulate lane plus the 64-entry result store that collects finished dot products.
- The controlling FSM drives operand pairs into the MAC, pulses clr to start each new dot product, and streams completed sums into the store with write_enable.
- The store fills in arrival order (auto-incrementing pointer) and exposes a combinational read port for readback and checking.

Parameters:
- IN_W, 8, operand width (signed two's complement)
- ACC_W, 19, accumulator / result width (signed)
- DEPTH, 64, result-store entries
- AW, 6, store address width (log2 DEPTH)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- inA  in  IN_W  signed operand A
- inB  in  IN_W  signed operand B
- clr  in  1  start new accumulation: next sum = current product only
- out  out  ACC_W  registered signed accumulator value
- wr_data  in  ACC_W  signed value to store
- write_enable  in  1  store wr_data at the current write pointer this edge
- rd_addr  in  AW  read address
- rd_data  out  ACC_W  combinational contents of mem[rd_addr]
- wr_count  out  AW+1  number of entries written so far (0..DEPTH)
- full  out  1  high when wr_count == DEPTH

Behaviour:
- One clock domain (clk). reset is asynchronous and active-high.
- Reset values: out=0, wr_count=0, full=0, all memory entries=0, so rd_data=0.
- Product: inA*inB, full signed, 2*IN_W bits, sign-extended to ACC_W.
- MAC update, registered with 1-cycle latency:
  - clr=1: out <= product (previous sum discarded; back-to-back dot products need no bubble cycle).
  - clr=0: out <= out + product.
  - Sum is modulo 2^ACC_W (two's-complement wrap, no saturation, no overflow flag).
- An 8-term dot product takes 8 edges:
  - First pair presented with clr=1, next 7 pairs with clr=0.
  - out holds the full sum after the 8th edge and keeps it until the next edge.
- Store write, registered:
  - If write_enable=1 and full=0: mem[wr_count] <= wr_data and wr_count <= wr_count+1.
  - If full=1: write ignored; memory and wr_count unchanged.
  - write_enable=0: no change.
- Entry order equals write order: entry k is the k-th accepted write.
- rd_data is combinational from rd_addr. Reading the location being written on the same edge returns the old value before the edge and the new value after it.
- MAC and store are independent; both may update on the same edge. wr_data may be tied to out externally.
- Reset mid-operation clears the accumulator, the pointer and memory at once; normal operation resumes on the first edge after reset deasserts.
- No handshake or backpressure beyond full; the controller must not issue more than DEPTH writes between resets.

Test Plan:
- Reset: assert reset asynchronously between edges -> out=0, wr_count=0, full=0, rd_data=0 for every address, all immediately without waiting for an edge.
- Dot product: pairs (1,1)..(8,1) with clr=1 on the first pair only -> out after edges 1..8 = 1,3,6,10,15,21,28,36. Then (2,3) with clr=1 -> out=6.
- Signed extremes: eight pairs (-128,-128) -> out=131072. Eight pairs (-128,127) -> out=-130048.
- Wrap: sixteen pairs (-128,-128) with clr only on the first pair -> out=-262144 (bit pattern 0x40000), no saturation.
- Store fill: 64 writes of values 0..63 -> rd_data[k]=k for all k, wr_count=64, full=1. A 65th write of 999 leaves mem[0]=0 and wr_count=64. Idle cycles with write_enable=0 leave the store unchanged.
- Reset mid-run: after 3 MAC edges and 5 store writes, pulse reset -> out=0, wr_count=0, rd_data[0..4]=0. The next write lands at address 0.
